// File: rtl/aud_seq_pkg.sv
// Shared types and defaults for the tone sequencer: FSM state encoding and note entry layout.
`timescale 1ns/1ps
package aud_seq_pkg;

    localparam int DEF_TICK_DIV = 50000;
    localparam int DEF_PERIOD_W = 24;
    localparam int DEF_DUR_W    = 12;
    localparam int DEF_ENTRY_W  = DEF_PERIOD_W + DEF_DUR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4,
        ADV   = 3'd5
    } state_t;

endpackage

// File: rtl/tone_sequencer_ram.sv
// Note list storage: one write port, one registered read port, read-first on address collision.
`timescale 1ns/1ps
module tone_sequencer_ram
    import aud_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = DEF_ENTRY_W
) (
    input  logic          clk50_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-address read returns the pre-write word.
    always_ff @(posedge clk50_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Steps through a programmed {period, duration} list and gates the square-wave tone generator.
`timescale 1ns/1ps
module tone_sequencer
    import aud_seq_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int DUR_W    = DEF_DUR_W,
    parameter int GAP_W    = 8
) (
    input  logic                clk50_i,
    input  logic                rst_n_i,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [PERIOD_W-1:0] wr_period_i,
    input  logic [DUR_W-1:0]    wr_dur_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                loop_i,
    input  logic [AW-1:0]       len_i,
    input  logic [GAP_W-1:0]    gap_i,
    output logic [PERIOD_W-1:0] period_o,
    output logic                tone_en_o,
    output logic                busy_o,
    output logic [AW-1:0]       note_idx_o,
    output logic                done_o,
    output logic [2:0]          state_o
);

    localparam int ENTRY_W = PERIOD_W + DUR_W;
    localparam int TICKS_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam int CNT_W   = TICKS_W + $clog2(TICK_DIV);

    state_t              state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                tone_en_q, tone_en_d;
    logic [AW-1:0]       note_idx_q, note_idx_d;
    logic                done_q, done_d;

    logic                rd_en;
    logic [ENTRY_W-1:0]  rd_data;
    logic [PERIOD_W-1:0] rd_period;
    logic [DUR_W-1:0]    rd_dur;
    logic [CNT_W-1:0]    dur_cycles;
    logic [CNT_W-1:0]    gap_cycles;

    tone_sequencer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_ram (
        .clk50_i   (clk50_i),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i ({wr_period_i, wr_dur_i}),
        .rd_en_i   (rd_en),
        .rd_addr_i (idx_q),
        .rd_data_o (rd_data)
    );

    assign rd_period  = rd_data[ENTRY_W-1:DUR_W];
    assign rd_dur     = rd_data[DUR_W-1:0];
    assign dur_cycles = CNT_W'(rd_dur) * CNT_W'(TICK_DIV);
    assign gap_cycles = CNT_W'(gap_i) * CNT_W'(TICK_DIV);

    // cnt_q holds remaining cycles minus one, so PLAY and GAP last exactly ticks*TICK_DIV cycles.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        tone_en_d  = tone_en_q;
        note_idx_d = note_idx_q;
        done_d     = 1'b0;
        rd_en      = 1'b0;
        if (stop_i) begin
            state_d   = IDLE;
            tone_en_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        idx_d   = '0;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    rd_en   = 1'b1;
                    state_d = LOAD;
                end
                LOAD: begin
                    period_d   = rd_period;
                    note_idx_d = idx_q;
                    if (rd_dur == '0) begin
                        tone_en_d = 1'b0;
                        state_d   = ADV;
                    end else begin
                        tone_en_d = (rd_period != '0);
                        cnt_d     = dur_cycles - CNT_W'(1);
                        state_d   = PLAY;
                    end
                end
                PLAY: begin
                    if (cnt_q == '0) begin
                        tone_en_d = 1'b0;
                        if (gap_i != '0) begin
                            cnt_d   = gap_cycles - CNT_W'(1);
                            state_d = GAP;
                        end else begin
                            state_d = ADV;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ADV;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ADV: begin
                    if (idx_q != len_i) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = FETCH;
                    end else if (loop_i) begin
                        idx_d   = '0;
                        state_d = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk50_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            period_q   <= '0;
            tone_en_q  <= 1'b0;
            note_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            tone_en_q  <= tone_en_d;
            note_idx_q <= note_idx_d;
            done_q     <= done_d;
        end
    end

    assign period_o   = period_q;
    assign tone_en_o  = tone_en_q;
    assign note_idx_o = note_idx_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q != IDLE);
    assign state_o    = state_q;

endmodule
